controlador_tx: RTL

Transmit-side link sequencer that drives the byte path of the PCIE transmitter (8-bit data, K flag, TxElecIdle) at the byte clock. It holds the line in electrical idle and sends training ordered sets when the link is enabled. In the link-up state it forwards bytes from an upstream requester through a valid/ready handshake and inserts SKP ordered sets at a fixed interval. Its outputs feed the to8bit/encoder path with dataS fixed at 8-bit width.

---
 rtl/controlador_tx_if.sv | 27 ++
 rtl/controlador_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/controlador_tx_if.sv
// controlador_tx_if: byte-path bundle between the upstream requester, the transmit
// sequencer and the encoder path.
//   dataValid/dataByte/dataK  requester -> sequencer, qualified by dataReady
//   dataReady                 sequencer -> requester, a transfer is dataValid & dataReady
//   dataOut/K/TxElecIdle      sequencer -> encoder path, registered symbol stream
//   linkUp                    sequencer status, registered
// master: the requester/observer side. slave: the sequencer.
interface controlador_tx_if;
    logic       dataValid;
    logic [7:0] dataByte;
    logic       dataK;
    logic       dataReady;
    logic [7:0] dataOut;
    logic       K;
    logic       TxElecIdle;
    logic       linkUp;

    modport master (
        output dataValid, dataByte, dataK,
        input  dataReady, dataOut, K, TxElecIdle, linkUp
    );

    modport slave (
        input  dataValid, dataByte, dataK,
        output dataReady, dataOut, K, TxElecIdle, linkUp
    );
endinterface

// File: rtl/controlador_tx.sv
// controlador_tx: transmit-side link sequencer for the 8-bit PCIe byte path.
// Holds the line in electrical idle, sends N_TRAIN training ordered sets when linkEn
// rises, then forwards requester bytes and inserts a SKP ordered set after every
// SKP_INTERVAL data slots.
//   clk     byte clock, rising edge
//   rst     synchronous active-high reset (overrides enb)
//   enb     global enable; 0 freezes every register and blocks the handshake
//   linkEn  bring the link up (1) or down (0)
//   bus     slave side of controlador_tx_if (handshake in, symbol stream out)
module controlador_tx #(
    parameter int unsigned SKP_INTERVAL = 16,
    parameter int unsigned N_TRAIN      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enb,
    input  logic            linkEn,
    controlador_tx_if.slave bus
);

    localparam logic [7:0] SymCom  = 8'hBC;
    localparam logic [7:0] SymSkp  = 8'h1C;
    localparam logic [7:0] SymFill = 8'h4A;
    localparam logic [7:0] SymIdle = 8'h00;

    localparam logic [7:0] TrainLast = 8'(N_TRAIN * 4 - 1);
    localparam logic [7:0] DataLast  = 8'(SKP_INTERVAL - 1);

    typedef enum logic [1:0] {
        StIdle,
        StTrain,
        StData,
        StSkp
    } estado_t;

    estado_t    estado;
    logic [7:0] cnt;
    logic [7:0] dout_q;
    logic       k_q;
    logic       elec_idle_q;
    logic       link_up_q;

    // Only data slots accept bytes; SKP sets and link-down edges never do.
    assign bus.dataReady  = ~rst & enb & linkEn & (estado == StData);
    assign bus.dataOut    = dout_q;
    assign bus.K          = k_q;
    assign bus.TxElecIdle = elec_idle_q;
    assign bus.linkUp     = link_up_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado      <= StIdle;
            cnt         <= 8'd0;
            dout_q      <= SymIdle;
            k_q         <= 1'b0;
            elec_idle_q <= 1'b1;
            link_up_q   <= 1'b0;
        end else if (enb) begin
            // linkUp trails the state by one edge so it lines up with the first data
            // slot on dataOut.
            link_up_q <= (estado == StData) || (estado == StSkp);

            case (estado)
                StIdle: begin
                    if (linkEn) begin
                        estado <= StTrain;
                        cnt    <= 8'd0;
                    end else begin
                        dout_q      <= SymIdle;
                        k_q         <= 1'b0;
                        elec_idle_q <= 1'b1;
                    end
                end

                StTrain: begin
                    dout_q      <= (cnt[1:0] == 2'd0) ? SymCom : SymFill;
                    k_q         <= (cnt[1:0] == 2'd0);
                    elec_idle_q <= 1'b0;
                    // Link-down is only honoured once the current set is complete.
                    if (cnt[1:0] == 2'd3 && !linkEn) begin
                        estado <= StIdle;
                        cnt    <= 8'd0;
                    end else if (cnt == TrainLast) begin
                        estado <= StData;
                        cnt    <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                StData: begin
                    if (!linkEn) begin
                        estado      <= StIdle;
                        cnt         <= 8'd0;
                        dout_q      <= SymIdle;
                        k_q         <= 1'b0;
                        elec_idle_q <= 1'b1;
                    end else begin
                        // dataReady is high here, so dataValid alone means a transfer.
                        if (bus.dataValid) begin
                            dout_q <= bus.dataByte;
                            k_q    <= bus.dataK;
                        end else begin
                            dout_q <= SymIdle;
                            k_q    <= 1'b0;
                        end
                        elec_idle_q <= 1'b0;
                        if (cnt == DataLast) begin
                            estado <= StSkp;
                            cnt    <= 8'd0;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end

                StSkp: begin
                    dout_q      <= (cnt[1:0] == 2'd0) ? SymCom : SymSkp;
                    k_q         <= 1'b1;
                    elec_idle_q <= 1'b0;
                    if (cnt[1:0] == 2'd3) begin
                        estado <= linkEn ? StData : StIdle;
                        cnt    <= 8'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    estado <= StIdle;
                    cnt    <= 8'd0;
                end
            endcase
        end
    end

endmodule
